// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding, default widths and timing constants for the sequential divider
package divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;
  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF = 8;
  localparam int DIV_LATENCY = DIVIDEND_W_DEF + 2;
  localparam int CNT_W = $clog2(DIVIDEND_W_DEF + 1);
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration on magnitudes
module divider_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] dsr,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;
  // shift the next dividend bit in, trial-subtract, keep the difference only when it stayed non-negative
  always_comb begin
    shifted = {rem_in, bit_in};
    diff = shifted - {2'b00, dsr};
    q_bit = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative signed restoring divider, one quotient bit per clock; optional ABORT via DIVIDER_ABORT_EN
module seq_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
`ifdef DIVIDER_ABORT_EN
  input  logic                  ABORT,
`endif
  input  logic [DIVIDEND_W-1:0] DIVIDEND,
  input  logic [DIVISOR_W-1:0]  DIVISOR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DIVIDEND_W-1:0] QUOTIENT,
  output logic [DIVISOR_W-1:0]  REMAINDER,
  output logic                  OVERFLOW,
  output logic                  DIV_BY_ZERO
);
  localparam int CW = $clog2(DIVIDEND_W + 1);
  localparam logic [DIVIDEND_W-1:0] MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};
  state_t state;
  logic [CW-1:0] cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0] dsr;
  logic [DIVISOR_W:0] rem;
  logic [DIVISOR_W:0] rem_next;
  logic q_bit;
  logic neg_q;
  logic neg_r;
  logic ovf_pend;
  logic dbz_pend;
  logic [DIVIDEND_W-1:0] q_res;
  logic [DIVISOR_W-1:0] r_res;
  logic abort;
`ifdef DIVIDER_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif
  divider_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in (rem),
    .bit_in (dvd[DIVIDEND_W-1]),
    .dsr    (dsr),
    .rem_out(rem_next),
    .q_bit  (q_bit)
  );
  // control FSM plus datapath; dvd doubles as the quotient shift register while CALC runs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf_pend <= 1'b0;
      dbz_pend <= 1'b0;
      q_res <= '0;
      r_res <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      QUOTIENT <= '0;
      REMAINDER <= '0;
      OVERFLOW <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          BUSY <= 1'b1;
          OVERFLOW <= 1'b0;
          DIV_BY_ZERO <= 1'b0;
          neg_q <= DIVIDEND[DIVIDEND_W-1] ^ DIVISOR[DIVISOR_W-1];
          neg_r <= DIVIDEND[DIVIDEND_W-1];
          ovf_pend <= (DIVIDEND == MOST_NEG) && (DIVISOR == '1);
          dbz_pend <= DIVISOR == '0;
          dvd <= DIVIDEND[DIVIDEND_W-1] ? -DIVIDEND : DIVIDEND;
          dsr <= DIVISOR[DIVISOR_W-1] ? -DIVISOR : DIVISOR;
          rem <= '0;
          cnt <= CW'(DIVIDEND_W);
          q_res <= '1;
          r_res <= '0;
          state <= (DIVISOR == '0) ? FINISH : CALC;
        end
        CALC: if (abort) begin
          state <= IDLE;
          BUSY <= 1'b0;
        end else begin
          rem <= rem_next;
          dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
          cnt <= cnt - 1'b1;
          state <= (cnt == CW'(1)) ? FIX : CALC;
        end
        FIX: if (abort) begin
          state <= IDLE;
          BUSY <= 1'b0;
        end else begin
          q_res <= neg_q ? -dvd : dvd;
          r_res <= neg_r ? -rem[DIVISOR_W-1:0] : rem[DIVISOR_W-1:0];
          state <= FINISH;
        end
        FINISH: begin
          QUOTIENT <= q_res;
          REMAINDER <= r_res;
          OVERFLOW <= ovf_pend;
          DIV_BY_ZERO <= dbz_pend;
          DONE <= 1'b1;
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
